// File: rtl/cs_frame_ctrl.sv
// cs_frame_ctrl: frame sequencer feeding the CS smoothing core; optional CS_CHKSUM_EN adds a result checksum port
module cs_frame_ctrl #(
  parameter int AW       = 12,
  parameter int CORE_LAT = 1,
  parameter int WIN      = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] rd_base,
  input  logic [AW-1:0] wr_base,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          cs_reset,
  output logic [7:0]    cs_x,
  input  logic [9:0]    cs_y,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [9:0]    wr_data
`ifdef CS_CHKSUM_EN
  ,
  output logic [15:0]   chksum
`endif
);
  localparam int D = 2 + CORE_LAT;
  localparam logic [AW:0] L_WIN = (AW+1)'(WIN);
  localparam logic [AW:0] L_WM1 = (AW+1)'(WIN - 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [AW:0]   r_len;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_rd_base;
  logic [AW-1:0] r_wr_base;
  logic [D-1:0]  r_v;
  logic [AW:0]   r_idx [D];
  logic [7:0]    r_cs_x;
  logic          r_err;
  logic          w_accept;
  logic          w_last_rd;
  logic          w_pipe_end;
  logic [AW:0]   w_idx;
  assign w_accept   = r_state == S_IDLE && start && len >= L_WIN;
  assign w_last_rd  = r_cnt == r_len - (AW+1)'(1);
  assign w_pipe_end = ~|r_v[D-2:0];
  assign w_idx      = r_idx[D-1];
  assign busy       = r_state == S_CLR || r_state == S_RUN || r_state == S_DRAIN;
  assign done       = r_state == S_DONE;
  assign err        = r_err;
  assign cs_reset   = reset || r_state == S_CLR;
  assign cs_x       = r_cs_x;
  assign rd_en      = r_state == S_RUN;
  assign rd_addr    = rd_en ? r_rd_base + r_cnt[AW-1:0] : '0;
  assign wr_en      = r_v[D-1] && w_idx >= L_WM1;
  assign wr_addr    = wr_en ? r_wr_base + AW'(w_idx - L_WM1) : '0;
  assign wr_data    = wr_en ? cs_y : '0;
  // next state: RUN ends on the len-th read, DRAIN ends once the last write is leaving the pipe
  always_comb begin
    w_next = r_state == S_IDLE  ? (w_accept ? S_CLR : S_IDLE) :
             r_state == S_CLR   ? S_RUN :
             r_state == S_RUN   ? (w_last_rd ? S_DRAIN : S_RUN) :
             r_state == S_DRAIN ? (w_pipe_end ? S_DONE : S_DRAIN) : S_IDLE;
  end
  // state, frame parameters, read counter and reject pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_rd_base <= '0;
      r_wr_base <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= r_state == S_IDLE && start && len < L_WIN;
      r_cnt   <= r_state == S_RUN ? r_cnt + (AW+1)'(1) : '0;
      if (w_accept) begin
        r_len     <= len;
        r_rd_base <= rd_base;
        r_wr_base <= wr_base;
      end
    end
  end
  // valid/index pipe: stage 0 = rd_data cycle, stage 1 = cs_x cycle, last stage = cs_y cycle
  always_ff @(posedge clk) begin
    r_v      <= reset ? '0 : {r_v[D-2:0], rd_en};
    r_idx[0] <= r_cnt;
    for (int i = 1; i < D; i++) r_idx[i] <= r_idx[i-1];
  end
  // sample register toward the core, holds when nothing valid arrives
  always_ff @(posedge clk) begin
    if (reset) r_cs_x <= '0;
    else if (r_v[0]) r_cs_x <= rd_data;
  end
`ifdef CS_CHKSUM_EN
  logic [15:0] r_chksum;
  assign chksum = r_chksum;
  // running sum of written results, restarted on each accepted frame
  always_ff @(posedge clk) begin
    if (reset || w_accept) r_chksum <= '0;
    else if (wr_en) r_chksum <= r_chksum + {6'd0, wr_data};
  end
`endif
endmodule

// File: tb/tb_cs_frame_ctrl.sv
// tb_cs_frame_ctrl: table-driven frame checks plus err, restart, mid-frame reset and optional checksum sequences
module tb_cs_frame_ctrl;
  localparam int AW = 12;
  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW:0]   len;
  logic [AW-1:0] rd_base, wr_base, rd_addr, wr_addr;
  logic          busy, done, err, rd_en, cs_reset, wr_en;
  logic [7:0]    rd_data, cs_x;
  logic [9:0]    cs_y, wr_data;
`ifdef CS_CHKSUM_EN
  logic [15:0]   chksum;
`endif
  always #5 clk = ~clk;
  cs_frame_ctrl #(.AW(AW), .CORE_LAT(1), .WIN(9)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .rd_base(rd_base), .wr_base(wr_base),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cs_reset(cs_reset), .cs_x(cs_x), .cs_y(cs_y), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef CS_CHKSUM_EN
    , .chksum(chksum)
`endif
  );
  logic [7:0] mem [4096];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  logic [7:0]  win [9];
  logic [11:0] wsum;
  logic        core_const = 1'b0;
  always @(posedge clk) begin
    for (int i = 8; i > 0; i--) win[i] <= cs_reset ? 8'd0 : win[i-1];
    win[0] <= cs_reset ? 8'd0 : cs_x;
  end
  always_comb begin
    wsum = '0;
    for (int i = 0; i < 9; i++) wsum = wsum + 12'(win[i]);
  end
  assign cs_y = core_const ? 10'h3FF : wsum[11:2];
  int n_vec = 0, n_bad = 0;
  int n_rd, n_rd_bad, n_csr, n_done, n_err, n_busy;
  int wa_q[$], wd_q[$];
  logic [AW-1:0] exp_rb;
  logic mon = 1'b0;
  always @(negedge clk) if (mon) begin
    if (rd_en) begin
      if (rd_addr != exp_rb + AW'(n_rd)) n_rd_bad++;
      n_rd++;
    end
    if (wr_en) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(wr_data));
    end
    n_csr += int'(cs_reset);
    n_done += int'(done);
    n_err += int'(err);
    n_busy += int'(busy);
  end
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic clr_mon();
    n_rd = 0; n_rd_bad = 0; n_csr = 0; n_done = 0; n_err = 0; n_busy = 0;
    wa_q.delete(); wd_q.delete();
  endtask
  function automatic int exp_y(input int rb, input int n);
    int s = 0;
    for (int j = n - 8; j <= n; j++) s += int'(mem[(rb + j) & 'hFFF]);
    return s >> 2;
  endfunction
  task automatic run_frame(input int l, input int rb, input int wb, input int restart_c, output int lat);
    clr_mon();
    exp_rb = AW'(rb);
    mon = 1'b1;
    @(negedge clk);
    start = 1'b1; len = (AW+1)'(l); rd_base = AW'(rb); wr_base = AW'(wb);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= l + 40; c++) begin
      @(negedge clk);
      if (done && lat < 0) lat = c;
      start = (c == restart_c);
      if (restart_c > 0) len = (AW+1)'(9);
      if (lat >= 0 && c >= lat + 4) break;
    end
    start = 1'b0;
    mon = 1'b0;
  endtask
  task automatic check_frame(input int l, input int rb, input int wb, input int nwr, input int elat, input int lat);
    chk("latency", lat, elat);
    chk("reads", n_rd, l);
    chk("rd_addr_errs", n_rd_bad, 0);
    chk("cs_reset_cycles", n_csr, 1);
    chk("done_pulses", n_done, 1);
    chk("busy_cycles", n_busy, elat);
    chk("writes", wa_q.size(), nwr);
    for (int i = 0; i < wa_q.size() && i < nwr; i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa_q[i], (wb + i) & 'hFFF);
      chk($sformatf("wr_data[%0d]", i), wd_q[i], exp_y(rb, i + 8));
    end
  endtask
  typedef struct { int l; int rb; int wb; int nwr; int lat; } vec_t;
  vec_t vt[3];
  int lat;
  initial begin
    vt[0] = '{9, 'h000, 'h100, 1, 13};
    vt[1] = '{20, 'hFFC, 'hFFE, 12, 24};
    vt[2] = '{12, 'h037, 'h005, 4, 16};
    for (int i = 0; i < 4096; i++) mem[i] = i < 9 ? 8'(i + 16) : 8'(i * 7 + 3);
    reset = 1'b1; start = 1'b0; len = '0; rd_base = '0; wr_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_rd", int'({rd_en, rd_addr}), 0);
    chk("rst_wr", int'({wr_en, wr_addr, wr_data}), 0);
    chk("rst_cs_x", int'(cs_x), 0);
    chk("rst_cs_reset", int'(cs_reset), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cs_reset", int'(cs_reset), 0);
    foreach (vt[i]) begin
      run_frame(vt[i].l, vt[i].rb, vt[i].wb, 0, lat);
      check_frame(vt[i].l, vt[i].rb, vt[i].wb, vt[i].nwr, vt[i].lat, lat);
    end
    clr_mon();
    mon = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 13'd8; rd_base = '0; wr_base = '0;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", int'(err), 1);
    repeat (4) @(negedge clk);
    mon = 1'b0;
    chk("err_count", n_err, 1);
    chk("err_busy", n_busy, 0);
    chk("err_reads", n_rd, 0);
    chk("err_cs_reset", n_csr, 0);
    run_frame(30, 'h200, 'h300, 10, lat);
    check_frame(30, 'h200, 'h300, 22, 34, lat);
    clr_mon();
    exp_rb = AW'('h40);
    mon = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 13'd20; rd_base = AW'('h40); wr_base = AW'('h80);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rd_en_5th", int'(rd_en), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rd", int'({rd_en, rd_addr}), 0);
    chk("mid_rst_wr", int'({wr_en, wr_addr, wr_data}), 0);
    chk("mid_rst_cs_x", int'(cs_x), 0);
    chk("mid_rst_cs_reset", int'(cs_reset), 1);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    mon = 1'b0;
    chk("mid_rst_writes", wa_q.size(), 0);
    chk("mid_rst_done", n_done, 0);
    chk("mid_rst_reads", n_rd, 5);
    run_frame(9, 'h000, 'h100, 0, lat);
    check_frame(9, 'h000, 'h100, 1, 13, lat);
`ifdef CS_CHKSUM_EN
    core_const = 1'b1;
    run_frame(11, 'h000, 'h000, 0, lat);
    chk("chk_writes", wa_q.size(), 3);
    chk("chksum", int'(chksum), 'h0BFD);
    core_const = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
